// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_pkg;

  localparam int unsigned MIN_PRESC   = 5;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_DATA_W  = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

  // Expected parity bit: even parity when odd = 0, odd parity when odd = 1.
  function automatic logic parity_exp(logic [MAX_DATA_W-1:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge/bit counters with a 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned BCNT_W  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               run,
  input  logic               rx,
  input  logic [PRESC_W-1:0] presc,
  output logic               bit_dec,
  output logic               bit_val,
  output logic [BCNT_W-1:0]  bit_cnt
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]         smp_q, smp_d;
  logic [PRESC_W-1:0] half;

  assign half = presc >> 1;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    // The start-detect cycle itself counts as edge 0 of the start bit.
    if (start) begin
      edge_cnt_d = PRESC_W'(1);
      bit_cnt_d  = '0;
    end else if (run) begin
      if (edge_cnt_q == presc - PRESC_W'(1)) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BCNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_W'(1);
      end
    end else begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
    if (edge_cnt_q == half - PRESC_W'(1)) smp_d[0] = rx;
    if (edge_cnt_q == half)               smp_d[1] = rx;
    if (edge_cnt_q == half + PRESC_W'(1)) smp_d[2] = rx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign bit_dec = run && (edge_cnt_q == half + PRESC_W'(2));
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, frame FSM, shift register and
// per-frame parity/stop error reporting.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 5);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall, start;
  rx_state_e              state_q, state_d;
  logic [PRESC_W-1:0]     presc_q, presc_d, presc_in;
  logic                   par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [DATA_W-1:0]      sh_q, sh_d, p_data_q, p_data_d;
  logic                   par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
  logic                   valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic                   frame_end;
  logic                   bit_dec, bit_val;
  logic [BCNT_W-1:0]      bit_cnt;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall     = rx_prev_q & ~rx_s;
  assign start    = (state_q == StIdle) && fall;
  assign presc_in = (Prescale < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : Prescale;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W),
    .BCNT_W  (BCNT_W)
  ) u_sampler (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .run     (state_q != StIdle),
    .rx      (rx_s),
    .presc   (presc_q),
    .bit_dec (bit_dec),
    .bit_val (bit_val),
    .bit_cnt (bit_cnt)
  );

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    sh_d       = sh_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    frame_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d    = StStart;
          presc_d    = presc_in;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_dec) state_d = bit_val ? StIdle : StData;
      end
      StData: begin
        if (bit_dec) begin
          sh_d = {bit_val, sh_q[DATA_W-1:1]};
          if (bit_cnt == BCNT_W'(DATA_W)) state_d = par_en_q ? StParity : StStop1;
        end
      end
      StParity: begin
        if (bit_dec) begin
          if (bit_val != parity_exp(MAX_DATA_W'(sh_q), par_typ_q)) par_flag_d = 1'b1;
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (bit_dec) begin
          if (!bit_val) stp_flag_d = 1'b1;
          if (stop2_q) state_d = StStop2;
          else         frame_end = 1'b1;
        end
      end
      StStop2: begin
        if (bit_dec) begin
          if (!bit_val) stp_flag_d = 1'b1;
          frame_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Returning to idle on the decision cycle leaves room for a back-to-back start edge.
    if (frame_end) begin
      state_d = StIdle;
      if (!par_flag_d && !stp_flag_d) begin
        valid_d  = 1'b1;
        p_data_d = sh_q;
      end else begin
        par_err_d = par_flag_d;
        stp_err_d = stp_flag_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      presc_q    <= PRESC_W'(MIN_PRESC);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      sh_q       <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      sh_q       <= sh_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8-bit and 9-bit instances, frame-level model with
// per-cycle comparison plus literal spot checks.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, rst9 = 1'b1;
  logic       rx8 = 1'b1, rx9 = 1'b1;
  logic [5:0] pres8 = 6'd8, pres9 = 6'd16;
  logic       pen8 = 1'b0, ptyp8 = 1'b0, st2_8 = 1'b0;
  logic       pen9 = 1'b0, ptyp9 = 1'b0, st2_9 = 1'b0;
  logic [7:0] pd8;
  logic [8:0] pd9;
  logic       dv8, pe8, se8, bz8, dv9, pe9, se9, bz9;

  uart_rx_cfg #(.DATA_W(8), .PRESC_W(6)) dut8 (
    .CLK(clk), .RST(rst8), .RX_IN(rx8), .Prescale(pres8), .PAR_EN(pen8), .PAR_TYP(ptyp8),
    .STOP2(st2_8), .P_DATA(pd8), .data_valid(dv8), .par_err(pe8), .stp_err(se8), .busy(bz8)
  );

  uart_rx_cfg #(.DATA_W(9), .PRESC_W(6)) dut9 (
    .CLK(clk), .RST(rst9), .RX_IN(rx9), .Prescale(pres9), .PAR_EN(pen9), .PAR_TYP(ptyp9),
    .STOP2(st2_9), .P_DATA(pd9), .data_valid(dv9), .par_err(pe9), .stp_err(se9), .busy(bz9)
  );

  // One expected frame outcome: busy window [t_on, t_end), result pulse at t_end.
  typedef struct {
    int         t_on;
    int         t_end;
    bit         ok;
    bit         pe;
    bit         se;
    logic [8:0] data;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [8:0] last_good [2] = '{9'd0, 9'd0};
  int         dv_n [2];
  int         pe_n [2];
  int         se_n [2];
  int         dv_cyc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int u, input logic [8:0] got,
                     input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s unit%0d cyc %0d: got %0h want %0h", name, u, cyc, got, want);
    end
  endtask

  task automatic push_exp(input int u, input exp_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_unit(input int u, input logic dv, input logic pe, input logic se,
                            input logic bz, input logic [8:0] pd);
    exp_t h;
    bit   have, e_dv, e_pe, e_se, e_bz;
    e_dv = 0; e_pe = 0; e_se = 0; e_bz = 0;
    have = (u == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) begin
      if (u == 0) h = q0[0];
      else        h = q1[0];
      if (cyc >= h.t_on && cyc < h.t_end) e_bz = 1;
      if (cyc == h.t_end) begin
        e_dv = h.ok;
        e_pe = h.pe;
        e_se = h.se;
        if (h.ok) last_good[u] = h.data;
        if (u == 0) q0.delete(0);
        else        q1.delete(0);
      end
    end
    if (dv) begin
      dv_n[u]++;
      dv_cyc[u] = cyc;
    end
    if (pe) pe_n[u]++;
    if (se) se_n[u]++;
    chk("data_valid", u, 9'(dv), 9'(e_dv));
    chk("par_err", u, 9'(pe), 9'(e_pe));
    chk("stp_err", u, 9'(se), 9'(e_se));
    chk("busy", u, 9'(bz), 9'(e_bz));
    chk("P_DATA", u, pd, last_good[u]);
  endtask

  always begin
    @(negedge clk);
    #1;
    check_unit(0, dv8, pe8, se8, bz8, {1'b0, pd8});
    check_unit(1, dv9, pe9, se9, bz9, pd9);
  end

  task automatic drive_rx(input int u, input logic v);
    if (u == 0) rx8 = v;
    else        rx9 = v;
  endtask

  // Called at a negedge; drives one frame P cycles per bit, optionally flipping
  // one cycle at mid-bit of bit index gbit, then idle cycles at idle_v.
  task automatic send_frame(input int u, input int p, input int dw, input logic [8:0] data,
                            input bit pen, input bit ptyp, input bit pbit, input bit st2,
                            input bit sv1, input bit sv2, input int gbit, input bit idle_v,
                            input int idle, output int s);
    logic seq [16];
    int   n;
    bit   par;
    exp_t e;
    n = 0;
    par = ptyp;
    seq[n] = 1'b0; n = n + 1;
    for (int i = 0; i < dw; i++) begin
      seq[n] = data[i]; n = n + 1;
      par = par ^ data[i];
    end
    if (pen) begin seq[n] = pbit; n = n + 1; end
    seq[n] = sv1; n = n + 1;
    if (st2) begin seq[n] = sv2; n = n + 1; end
    if (u == 0) begin pres8 = 6'(p); pen8 = pen; ptyp8 = ptyp; st2_8 = st2; end
    else        begin pres9 = 6'(p); pen9 = pen; ptyp9 = ptyp; st2_9 = st2; end
    s       = cyc + 2;  // two synchroniser stages
    e.t_on  = s + 1;
    e.t_end = s + p * (n - 1) + p / 2 + 3;
    e.pe    = pen && (pbit != par);
    e.se    = !sv1 || (st2 && !sv2);
    e.ok    = !e.pe && !e.se;
    e.data  = data;
    push_exp(u, e);
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < p; j++) begin
        drive_rx(u, seq[b] ^ ((b == gbit) && (j == p / 2)));
        @(negedge clk);
      end
    end
    for (int j = 0; j < idle; j++) begin
      drive_rx(u, idle_v);
      @(negedge clk);
    end
  endtask

  task automatic send_glitch(input int u, input int p, input int low);
    exp_t e;
    int   s;
    s       = cyc + 2;
    e.t_on  = s + 1;
    e.t_end = s + p / 2 + 3;
    e.ok    = 0;
    e.pe    = 0;
    e.se    = 0;
    e.data  = '0;
    push_exp(u, e);
    for (int j = 0; j < low; j++) begin drive_rx(u, 1'b0); @(negedge clk); end
    for (int j = 0; j < 2 * p; j++) begin drive_rx(u, 1'b1); @(negedge clk); end
  endtask

  initial begin
    int   s;
    exp_t e;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_P_DATA8", 0, {1'b0, pd8}, 9'h000);
    chk("rst_busy8", 0, 9'(bz8), 9'h000);
    chk("rst_P_DATA9", 1, pd9, 9'h000);
    @(negedge clk);
    rst8 = 1'b0;
    rst9 = 1'b0;
    repeat (4) @(negedge clk);

    // Clean 0xA5, P=8, no parity, one stop.
    send_frame(0, 8, 8, 9'h0A5, 0, 0, 0, 0, 1, 1, -1, 1, 12, s);
    #2;
    chk("t1_P_DATA", 0, {1'b0, pd8}, 9'h0A5);
    chk("t1_valid_count", 0, 9'(dv_n[0]), 9'd1);
    chk("t1_latency", 0, 9'(dv_cyc[0] - s), 9'd79);

    // Even parity, 0x07 sent with parity 0.
    send_frame(0, 8, 8, 9'h007, 1, 0, 0, 0, 1, 1, -1, 1, 12, s);
    #2;
    chk("t2_par_count", 0, 9'(pe_n[0]), 9'd1);
    chk("t2_valid_count", 0, 9'(dv_n[0]), 9'd1);
    chk("t2_P_DATA_held", 0, {1'b0, pd8}, 9'h0A5);

    // Two stop bits, second one 0, then clean 0x3C (odd parity in use).
    send_frame(0, 8, 8, 9'h055, 1, 1, 1, 1, 1, 0, -1, 1, 12, s);
    #2;
    chk("t3_stp_count", 0, 9'(se_n[0]), 9'd1);
    chk("t3_par_count", 0, 9'(pe_n[0]), 9'd1);
    send_frame(0, 8, 8, 9'h03C, 1, 1, 1, 1, 1, 1, -1, 1, 12, s);
    #2;
    chk("t3_valid_count", 0, 9'(dv_n[0]), 9'd2);
    chk("t3_P_DATA", 0, {1'b0, pd8}, 9'h03C);

    // Short low pulse on the line: rejected start.
    send_glitch(0, 8, 3);
    #2;
    chk("t4_busy", 0, 9'(bz8), 9'h000);
    chk("t4_valid_count", 0, 9'(dv_n[0]), 9'd2);
    chk("t4_err_count", 0, 9'(pe_n[0] + se_n[0]), 9'd2);

    // One-cycle glitch at mid-sample of data bit 2.
    send_frame(0, 8, 8, 9'h096, 0, 0, 0, 0, 1, 1, 3, 1, 12, s);
    #2;
    chk("t5_valid_count", 0, 9'(dv_n[0]), 9'd3);
    chk("t5_P_DATA", 0, {1'b0, pd8}, 9'h096);

    // Break: line held low well past the frame, then released.
    send_frame(0, 8, 8, 9'h000, 0, 0, 0, 0, 0, 0, -1, 0, 20, s);
    for (int j = 0; j < 12; j++) begin rx8 = 1'b1; @(negedge clk); end
    #2;
    chk("brk_stp_count", 0, 9'(se_n[0]), 9'd2);
    chk("brk_valid_count", 0, 9'(dv_n[0]), 9'd3);
    chk("brk_busy", 0, 9'(bz8), 9'h000);

    // 9-bit instance, P=16, back-to-back frames.
    send_frame(1, 16, 9, 9'h1FF, 0, 0, 0, 0, 1, 1, -1, 1, 0, s);
    send_frame(1, 16, 9, 9'h000, 0, 0, 0, 0, 1, 1, -1, 1, 20, s);
    #2;
    chk("t6_valid_count", 1, 9'(dv_n[1]), 9'd2);
    chk("t6_P_DATA", 1, pd9, 9'h000);
    chk("t6_latency", 1, 9'(dv_cyc[1] - s), 9'd171);

    // Reset in the middle of a frame.
    @(negedge clk);
    s       = cyc + 2;
    e.t_on  = s + 1;
    e.t_end = s + 100000;
    e.ok    = 0;
    e.pe    = 0;
    e.se    = 1;
    e.data  = '0;
    push_exp(0, e);
    rx8 = 1'b0;
    repeat (30) @(negedge clk);
    rst8 = 1'b1;
    q0.delete();
    last_good[0] = '0;
    rx8 = 1'b1;
    #2;
    chk("mid_rst_P_DATA", 0, {1'b0, pd8}, 9'h000);
    chk("mid_rst_busy", 0, 9'(bz8), 9'h000);
    chk("mid_rst_valid", 0, 9'(dv8), 9'h000);
    repeat (3) @(negedge clk);
    rst8 = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(0, 8, 8, 9'h05A, 0, 0, 0, 0, 1, 1, -1, 1, 12, s);
    #2;
    chk("post_rst_P_DATA", 0, {1'b0, pd8}, 9'h05A);
    chk("post_rst_valid_count", 0, 9'(dv_n[0]), 9'd4);

    repeat (4) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
